// File: rtl/psi_table_gen.sv
// -----------------------------------------------------------------------------
// psi_table_gen
//   Twiddle-factor table for the NTT datapath. An init pulse fills an N-entry
//   RAM with psi^k mod Q (forward) or psi^-k mod Q (inverse), one entry per
//   cycle. The table is then read through a registered random-access port.
//
//   Optional build macro: PSI_BITREV_EN
//     defined   : read index is the bit-reverse of rd_addr over LOG_N bits
//     undefined : read index is rd_addr (natural order)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   init     in   single-cycle pulse: start or restart the table fill
//   inverse  in   mode, sampled on the init cycle (0 = PSI, 1 = PSI_INV)
//   busy     out  fill in progress
//   ready    out  table fully valid for the last sampled mode
//   rd_en    in   read request
//   rd_addr  in   read index
//   rd_data  out  registered read data
//   rd_valid out  rd_data valid, one cycle after an accepted rd_en
//   rd_err   out  one-cycle pulse: rd_en arrived while ready = 0
//
// FSM states
//   state  | meaning
//   IDLE   | no valid table since reset
//   FILL   | writing mem[k] = acc, one entry per cycle
//   DONE   | table valid, reads accepted
// -----------------------------------------------------------------------------
module psi_table_gen #(
  parameter int WIDTH   = 17,
  parameter int LOG_N   = 4,
  parameter int Q       = 65537,
  parameter int PSI     = 2,
  parameter int PSI_INV = 32769
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             inverse,
  output logic             busy,
  output logic             ready,
  input  logic             rd_en,
  input  logic [LOG_N-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err
);

  localparam int N = 1 << LOG_N;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0]   PSI_W     = WIDTH'(PSI);
  localparam logic [WIDTH-1:0]   PSI_INV_W = WIDTH'(PSI_INV);
  localparam logic [2*WIDTH-1:0] Q_EXT     = (2*WIDTH)'(Q);
  localparam logic [LOG_N-1:0]   K_LAST    = LOG_N'(N - 1);

  logic [1:0]         state;
  logic [LOG_N-1:0]   k;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   base;
  logic [WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [LOG_N-1:0]   idx;
  logic               wr_en;
  logic               rd_accept;

  logic [WIDTH-1:0] mem [N];

  // Full-width product followed by an exact reduction; acc and base are both
  // below Q so the remainder always fits back into WIDTH bits.
  assign prod     = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base};
  assign acc_next = WIDTH'(prod % Q_EXT);

  // A restart on the same cycle discards the in-flight write.
  assign wr_en     = (state == S_FILL) && !init;
  assign rd_accept = rd_en && ready;

`ifdef PSI_BITREV_EN
  always_comb begin
    idx = '0;
    for (int i = 0; i < LOG_N; i++) begin
      idx[i] = rd_addr[LOG_N-1-i];
    end
  end
`else
  assign idx = rd_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      k     <= '0;
      acc   <= WIDTH'(1);
      base  <= PSI_W;
    end else if (init) begin
      state <= S_FILL;
      busy  <= 1'b1;
      ready <= 1'b0;
      k     <= '0;
      acc   <= WIDTH'(1);
      base  <= inverse ? PSI_INV_W : PSI_W;
    end else begin
      case (state)
        S_FILL: begin
          k   <= k + 1'b1;
          acc <= acc_next;
          if (k == K_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // No reset on the table itself; its contents are meaningless until ready.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[k] <= acc;
    end
  end

  // Reads are only accepted in DONE, where no writes occur, so read and write
  // never collide on the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      rd_err   <= rd_en && !ready;
      if (rd_accept) begin
        rd_data <= mem[idx];
      end
    end
  end

endmodule
